// File: rtl/vga_pattern_gen_pkg.sv
// Shared VGA definitions: mode encodings, default 640x480@60 timing, bar colours.
package vga_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INVALID = 2'd0,
        MODE_BAR     = 2'd1,
        MODE_CHAR    = 2'd2,
        MODE_CUSTOM  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned BAR_W    = 80;
    localparam int unsigned NUM_BARS = 8;

    localparam pixel_t BAR_WHITE   = 24'hFFFFFF;
    localparam pixel_t BAR_YELLOW  = 24'hFFFF00;
    localparam pixel_t BAR_CYAN    = 24'h00FFFF;
    localparam pixel_t BAR_GREEN   = 24'h00FF00;
    localparam pixel_t BAR_MAGENTA = 24'hFF00FF;
    localparam pixel_t BAR_RED     = 24'hFF0000;
    localparam pixel_t BAR_BLUE    = 24'h0000FF;
    localparam pixel_t BAR_BLACK   = 24'h000000;

    // Counters need at least 10 bits: the CUSTOM pattern taps h_cnt[9:2] and v_cnt[8:1].
    function automatic int unsigned cnt_width(input int unsigned total);
        return ($clog2(total) > 10) ? $clog2(total) : 10;
    endfunction

    function automatic pixel_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video output bundle plus the mode request feeding the pattern generator.
interface vga_pattern_gen_if;
    import vga_pattern_gen_pkg::*;

    mode_e  mode;
    logic   hsync;
    logic   vsync;
    logic   de;
    pixel_t rgb;
    logic   frame_start;
    mode_e  mode_active;

    modport master (
        input  mode,
        output hsync, vsync, de, rgb, frame_start, mode_active
    );

    modport slave (
        output mode,
        input  hsync, vsync, de, rgb, frame_start, mode_active
    );
endinterface

// File: rtl/vga_timing.sv
// Pixel/line counters and raw (unregistered) sync and visible-area decode.
module vga_timing
    import vga_pattern_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          visible,
    output logic          hsync_raw,
    output logic          vsync_raw
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == VW'(V_TOTAL - 1)) v_cnt <= '0;
            else                           v_cnt <= v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign visible   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hsync_raw = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                         (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_raw = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                         (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: selects BAR/CHAR/CUSTOM pixels and registers all video outputs.
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    vga_pattern_gen_if.master  vif
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          visible;
    logic          hsync_raw;
    logic          vsync_raw;
    logic [2:0]    bar_idx_c;
    pixel_t        pix_c;
    logic          frame_origin_c;
    logic          frame_end_c;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW       (HW),       .VW   (VW)
    ) u_timing (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .visible   (visible),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw)
    );

    assign frame_origin_c = (h_cnt == '0) && (v_cnt == '0);
    assign frame_end_c    = (h_cnt == HW'(H_TOTAL - 1)) && (v_cnt == VW'(V_TOTAL - 1));

    // Bar index from threshold compares against multiples of the bar width.
    always_comb begin
        bar_idx_c = '0;
        for (int unsigned k = 1; k < NUM_BARS; k++) begin
            if (h_cnt >= HW'(k * BAR_W)) bar_idx_c = 3'(k);
        end
    end

    always_comb begin
        pix_c = '0;
        case (vif.mode_active)
            MODE_BAR:    pix_c = bar_color(bar_idx_c);
            MODE_CHAR:   pix_c = (h_cnt[3] ^ v_cnt[4]) ? pixel_t'(24'hFFFFFF) : pixel_t'(24'h000000);
            MODE_CUSTOM: pix_c = pixel_t'({h_cnt[9:2], v_cnt[8:1], 8'h80});
            default:     pix_c = '0;
        endcase
    end

    // Mode is only latched at the last pixel of a frame so a frame never changes pattern midway.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vif.hsync       <= 1'b1;
            vif.vsync       <= 1'b1;
            vif.de          <= 1'b0;
            vif.rgb         <= '0;
            vif.frame_start <= 1'b0;
            vif.mode_active <= MODE_BAR;
        end else begin
            vif.hsync       <= hsync_raw;
            vif.vsync       <= vsync_raw;
            vif.de          <= visible;
            vif.rgb         <= visible ? pix_c : '0;
            vif.frame_start <= frame_origin_c;
            if (frame_end_c) vif.mode_active <= vif.mode;
        end
    end
endmodule
